// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//   ID/EX pipeline register with operand forwarding and load-use detection.
//   The register captures the decoded instruction each cycle. It holds while
//   stall is high, and it loads a bubble when flush is high (flush wins).
//   The ALU operands are selected combinationally from the registered fields
//   and the EX/MEM and MEM/WB write-back buses.
//
// Configuration macro:
//   ALU_FORWARDING_EN - when defined, rs/rt values are forwarded from EX/MEM
//                       (highest priority) or MEM/WB. When undefined, the
//                       registered read data is used and the exmem_*/memwb_*
//                       inputs are ignored.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   stall, flush            hold / bubble control for the ID/EX register
//   id_valid, id_regwrite,
//   id_memread, id_alusrc   decoded ID-stage controls
//   id_rs, id_rt, id_rd     source and destination register numbers
//   id_data1, id_data2,
//   id_imm                  register read data and sign-extended immediate
//   id_sel                  ALU operation code
//   exmem_*, memwb_*        write enable, destination and result of the
//                           later stages
//   op1, op2, sel           ALU operands and operation code
//   ex_valid, ex_regwrite,
//   ex_memread, ex_rd       registered controls and destination
//   ex_store_data           forwarded rt value for stores
//   load_use_stall          combinational request to hold ID for one cycle
// ---------------------------------------------------------------------------
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        id_alusrc,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_data1,
    input  logic [31:0] id_data2,
    input  logic [31:0] id_imm,
    input  logic [2:0]  id_sel,
    input  logic        exmem_regwrite,
    input  logic        memwb_regwrite,
    input  logic [4:0]  exmem_rd,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] exmem_result,
    input  logic [31:0] memwb_result,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output logic [2:0]  sel,
    output logic        ex_valid,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic [4:0]  ex_rd,
    output logic [31:0] ex_store_data,
    output logic        load_use_stall
);

    logic        valid_q,    valid_d;
    logic        regwrite_q, regwrite_d;
    logic        memread_q,  memread_d;
    logic        alusrc_q,   alusrc_d;
    logic [4:0]  rs_q,       rs_d;
    logic [4:0]  rt_q,       rt_d;
    logic [4:0]  rd_q,       rd_d;
    logic [31:0] data1_q,    data1_d;
    logic [31:0] data2_q,    data2_d;
    logic [31:0] imm_q,      imm_d;
    logic [2:0]  sel_q,      sel_d;

    logic [31:0] rs_val;
    logic [31:0] rt_val;

    // Next-state selection: flush beats stall, stall beats capture.
    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        alusrc_d   = alusrc_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        rd_d       = rd_q;
        data1_d    = data1_q;
        data2_d    = data2_q;
        imm_d      = imm_q;
        sel_d      = sel_q;
        if (flush) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            alusrc_d   = 1'b0;
            rs_d       = 5'd0;
            rt_d       = 5'd0;
            rd_d       = 5'd0;
            data1_d    = 32'd0;
            data2_d    = 32'd0;
            imm_d      = 32'd0;
            sel_d      = 3'd0;
        end else if (!stall) begin
            valid_d    = id_valid;
            regwrite_d = id_regwrite;
            memread_d  = id_memread;
            alusrc_d   = id_alusrc;
            rs_d       = id_rs;
            rt_d       = id_rt;
            rd_d       = id_rd;
            data1_d    = id_data1;
            data2_d    = id_data2;
            imm_d      = id_imm;
            sel_d      = id_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            alusrc_q   <= 1'b0;
            rs_q       <= 5'd0;
            rt_q       <= 5'd0;
            rd_q       <= 5'd0;
            data1_q    <= 32'd0;
            data2_q    <= 32'd0;
            imm_q      <= 32'd0;
            sel_q      <= 3'd0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            alusrc_q   <= alusrc_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
            data1_q    <= data1_d;
            data2_q    <= data2_d;
            imm_q      <= imm_d;
            sel_q      <= sel_d;
        end
    end

`ifdef ALU_FORWARDING_EN
    // EX/MEM is the younger result, so it is checked first. Register 0 is
    // hard-wired to zero and must never pick up a forwarded value.
    always_comb begin
        rs_val = data1_q;
        if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == rs_q))
            rs_val = exmem_result;
        else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == rs_q))
            rs_val = memwb_result;
    end

    always_comb begin
        rt_val = data2_q;
        if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == rt_q))
            rt_val = exmem_result;
        else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == rt_q))
            rt_val = memwb_result;
    end
`else
    assign rs_val = data1_q;
    assign rt_val = data2_q;

    // Later-stage buses and registered source numbers have no consumer here.
    logic unused_fwd;
    assign unused_fwd = ^{exmem_regwrite, memwb_regwrite, exmem_rd, memwb_rd,
                          exmem_result, memwb_result, rs_q, rt_q};
`endif

    assign op1           = rs_val;
    assign op2           = alusrc_q ? imm_q : rt_val;
    assign sel           = sel_q;
    assign ex_valid      = valid_q;
    assign ex_regwrite   = regwrite_q;
    assign ex_memread    = memread_q;
    assign ex_rd         = rd_q;
    assign ex_store_data = rt_val;

    // A load in EX cannot forward its data in time for a dependent
    // instruction in ID; ask upstream to hold ID and bubble this stage.
    assign load_use_stall = valid_q && memread_q && (rd_q != 5'd0) && id_valid &&
                            ((rd_q == id_rs) || (rd_q == id_rt));

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 stall  input  1  hold the ID/EX register contents.
REQ-005 flush  input  1  insert a bubble into the ID/EX register.
REQ-006 id_valid, id_regwrite, id_memread, id_alusrc  input  1 each  decoded ID-stage controls.
REQ-007 id_rs, id_rt, id_rd  input  5 each  source and destination register numbers.
REQ-008 id_data1, id_data2, id_imm  input  32 each  register-file read data and sign-extended immediate.
REQ-009 id_sel  input  3  ALU operation code, carried unchanged to the ALU sel port.
REQ-010 exmem_regwrite, memwb_regwrite  input  1 each  write enables of the later stages.
REQ-011 exmem_rd, memwb_rd  input  5 each  destination registers of the later stages.
REQ-012 exmem_result, memwb_result  input  32 each  results of the later stages.
REQ-013 op1, op2  output  32 each  ALU operands.
REQ-014 sel  output  3  ALU operation code.
REQ-015 ex_valid, ex_regwrite, ex_memread  output  1 each  registered controls.
REQ-016 ex_rd  output  5  registered destination register.
REQ-017 ex_store_data  output  32  forwarded rt value for stores.
REQ-018 load_use_stall  output  1  request to the upstream stage to hold ID for one cycle.

Function
REQ-019 On each rising clk with stall=0 and flush=0, the ID/EX register SHALL capture every id_* input; the sel output SHALL equal the registered id_sel.
REQ-020 With stall=1, the register SHALL hold its value; stall SHALL take priority over the id_* inputs.
REQ-021 With flush=1, the block SHALL load a bubble: ex_valid, ex_regwrite and ex_memread set to 0, and all data fields set to 0. flush SHALL take priority over stall.
REQ-022 Latency SHALL be one cycle from the ID inputs to op1, op2 and sel; the forwarding muxes SHALL be combinational from the registered fields and the exmem_*/memwb_* inputs.
REQ-023 The forwarding source for rs SHALL be exmem_result when exmem_regwrite=1, exmem_rd!=0 and exmem_rd equals the registered rs.
REQ-024 Otherwise the rs source SHALL be memwb_result under the same three conditions on the memwb_* inputs.
REQ-025 Otherwise the rs source SHALL be the registered data1. EX/MEM SHALL win when both stages match.
REQ-026 op1 SHALL be the forwarded rs value.
REQ-027 The rt value SHALL be forwarded by the same rules and driven to ex_store_data.
REQ-028 op2 SHALL equal the registered imm when the registered alusrc=1, and the forwarded rt value otherwise.
REQ-029 Register 0 SHALL never be a forwarding match.
REQ-030 load_use_stall SHALL be 1 when ex_valid=1, ex_memread=1, ex_rd!=0, id_valid=1 and ex_rd equals id_rs or id_rt.
REQ-031 load_use_stall SHALL be combinational. The upstream stage SHALL respond by asserting flush on this block for that cycle.
REQ-032 When ex_valid=0, op1, op2 and sel SHALL still be driven, with don't-care meaning; no state SHALL change.

Reset
REQ-033 While rst_n=0, all registered fields SHALL be 0, independent of clk; resulting outputs: ex_valid=0, sel=000, op1=op2=0 (when no forwarding match is present), load_use_stall=0.
REQ-034 A reset asserted mid-operation SHALL discard the held instruction; the first edge after rst_n rises SHALL capture the ID inputs normally.

Configuration
REQ-035 Macro ALU_FORWARDING_EN: when defined, REQ-023 to REQ-027 apply.
REQ-036 When ALU_FORWARDING_EN is undefined, the rs and rt values SHALL always be the registered data1 and data2, and the exmem_*/memwb_* inputs SHALL be ignored; load_use_stall behaviour is unchanged.

Verification
REQ-037 Scenario 1: id_data1=10, id_data2=10, id_sel=010, alusrc=0, no hazards, one edge -> op1=10, op2=10, sel=010, ex_valid=1.
REQ-038 Scenario 2: registered rs=5 with exmem_regwrite=1, exmem_rd=5, exmem_result=7, and memwb also matching with result 9 -> op1=7; with exmem_rd=6 instead -> op1=9.
REQ-039 Scenario 3: exmem_rd=0, exmem_regwrite=1, exmem_result=99 -> op1 equals registered data1, not 99.
REQ-040 Scenario 4: EX holds a load with ex_rd=3 while ID has id_rt=3 -> load_use_stall=1; after the flush edge, ex_valid=0.
REQ-041 Scenario 5: stall=1 for 2 cycles with changing id_* inputs -> outputs constant; then flush=1 together with stall=1 -> bubble loaded.
REQ-042 Scenario 6: rst_n pulled low between edges while ex_valid=1 -> ex_valid=0 and sel=000 immediately; repeat the bench with ALU_FORWARDING_EN undefined and check that Scenario 2 gives op1 equal to registered data1.
